// File: rtl/prog_loader_if.sv
// Byte-stream download channel into the program loader.
// The source (master) drives bytes; the loader (slave) returns byte_ready.
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input  byte_ready);
  modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory front end: packs a downloaded byte stream into 16-bit
// words, pulses start when the image is complete, then serves fetches.
module prog_loader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic [AW-1:0] load_len,
  prog_loader_if.slave  bs,
  input  logic [AW-1:0] pc,
  input  logic          rom_en,
  output logic [DW-1:0] ir,
  output logic          start,
  output logic          busy,
  output logic          load_done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, KICK, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   len_q, len_d;
  logic [7:0]      hi_q, hi_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic            load_done_q, load_done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [2**AW];
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;

  // Handshake and status outputs come straight from the state register.
  assign bs.byte_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign busy          = (state_q == LOAD_HI) || (state_q == LOAD_LO) || (state_q == KICK);
  assign start         = (state_q == KICK);
  assign ir            = ir_q;
  assign load_done     = load_done_q;
  assign err           = err_q;

  // Next-state, word packing and fetch decode.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    hi_d        = hi_q;
    ir_d        = ir_q;
    load_done_d = load_done_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_wdata   = {hi_q, bs.byte_in};
    case (state_q)
      IDLE, RUN: begin
        // Fetches stay live in IDLE so an image survives a reset.
        if (rom_en) ir_d = mem_q[pc];
        if (load_req) begin
          state_d     = LOAD_HI;
          wcnt_d      = '0;
          len_d       = load_len;
          load_done_d = 1'b0;
        end
      end
      LOAD_HI: begin
        if (bs.byte_valid) begin
          hi_d    = bs.byte_in;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (bs.byte_valid) begin
          mem_we = 1'b1;
          // len==0 wraps to all-ones, giving a full 2^AW word load.
          if (wcnt_q == len_q - AW'(1)) begin
            state_d = KICK;
          end else begin
            wcnt_d  = wcnt_q + AW'(1);
            state_d = LOAD_HI;
          end
        end
      end
      KICK: begin
        load_done_d = 1'b1;
        state_d     = RUN;
      end
      default: state_d = IDLE;
    endcase
    // A fetch while the image is in flux is a processor bug; flag it.
    if (busy && rom_en) err_d = 1'b1;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      ir_q        <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      ir_q        <= ir_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  // Program memory; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wcnt_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, packed loads, gaps, full depth,
// reset mid-load and illegal fetch.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [7:0]  load_len;
  logic [7:0]  pc;
  logic        rom_en;
  logic [15:0] ir;
  logic        start, busy, load_done, err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int rdy_cnt;
  int c0;

  prog_loader_if bs();

  prog_loader #(.AW(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
    .bs(bs), .pc(pc), .rom_en(rom_en), .ir(ir), .start(start),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte presented for one edge; back-to-back calls stream continuously.
  task automatic send(input logic [7:0] b);
    bs.byte_in    = b;
    bs.byte_valid = 1'b1;
    if (bs.byte_ready) rdy_cnt++;
    tick();
    bs.byte_valid = 1'b0;
  endtask

  // Idle cycles with junk on the data bus that must not be consumed.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      bs.byte_in = 8'hEE;
      tick();
    end
  endtask

  task automatic fetch(input logic [7:0] a);
    pc     = a;
    rom_en = 1'b1;
    tick();
    rom_en = 1'b0;
  endtask

  task automatic req(input logic [7:0] n);
    load_req = 1'b1;
    load_len = n;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    // Reset with random inputs.
    rst = 1'b1;
    load_req = 1'($urandom); load_len = 8'($urandom); pc = 8'($urandom);
    rom_en = 1'($urandom); bs.byte_in = 8'($urandom); bs.byte_valid = 1'($urandom);
    tick();
    chk("rst_ir", ir, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bs.byte_ready, 0);
    tick();
    rst = 1'b0; load_req = 0; rom_en = 0; bs.byte_valid = 0; pc = 0;
    tick();
    chk("idle_ready", bs.byte_ready, 0);

    // 3-word continuous load.
    req(8'd3);
    chk("l3_busy", busy, 1);
    rdy_cnt = 0;
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A);
    chk("l3_nostart", start, 0);
    send(8'hBC);
    chk("l3_rdy_cnt", rdy_cnt, 6);
    chk("l3_start", start, 1);
    chk("l3_ready_off", bs.byte_ready, 0);
    tick();
    chk("l3_start_1cyc", start, 0);
    chk("l3_done", load_done, 1);
    chk("l3_busy_off", busy, 0);
    fetch(8'd0); chk("l3_ir0", ir, 16'h1234);
    fetch(8'd1); chk("l3_ir1", ir, 16'h5678);
    fetch(8'd2); chk("l3_ir2", ir, 16'h9ABC);
    tick();      chk("l3_ir_hold", ir, 16'h9ABC);

    // Reload from RUN with gaps in byte_valid.
    req(8'd3);
    chk("gp_busy", busy, 1);
    chk("gp_done_clr", load_done, 0);
    c0 = cyc;
    send(8'h12); gap(1); send(8'h34); send(8'h56); gap(1);
    send(8'h78); send(8'h9A); send(8'hBC);
    chk("gp_cycles", cyc - c0, 8);
    chk("gp_start", start, 1);
    chk("gp_ir_hold", ir, 16'h9ABC);
    tick();
    fetch(8'd0); chk("gp_ir0", ir, 16'h1234);
    fetch(8'd1); chk("gp_ir1", ir, 16'h5678);
    fetch(8'd2); chk("gp_ir2", ir, 16'h9ABC);

    // Full depth: word i = {i, ~i}.
    req(8'd0);
    rdy_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      send(8'(i));
      send(~8'(i));
    end
    send(8'hFF);
    chk("fd_nostart", start, 0);
    chk("fd_ready", bs.byte_ready, 1);
    send(8'h00);
    chk("fd_rdy_cnt", rdy_cnt, 512);
    chk("fd_start", start, 1);
    tick();
    fetch(8'hFF); chk("fd_irFF", ir, 16'hFF00);
    fetch(8'h00); chk("fd_ir00", ir, 16'h00FF);
    fetch(8'h5A); chk("fd_ir5A", ir, 16'h5AA5);

    // Reset after 3 bytes of a 4-word load.
    req(8'd4);
    send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_start", start, 0);
    chk("rm_done", load_done, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ir", ir, 0);
    gap(3);
    chk("rm_nostart", start, 0);
    fetch(8'd0); chk("rm_w0", ir, 16'h1122);
    fetch(8'd1); chk("rm_w1", ir, 16'h01FE);
    req(8'd1);
    send(8'hAA); send(8'h55);
    chk("rm_new_start", start, 1);
    tick();
    fetch(8'd0); chk("rm_new_w0", ir, 16'hAA55);

    // Illegal fetch during a load; load_req while busy ignored.
    req(8'd1);
    pc = 8'd1; rom_en = 1'b1;
    tick();
    rom_en = 1'b0;
    chk("il_err", err, 1);
    chk("il_ir", ir, 16'hAA55);
    send(8'h00);
    load_req = 1'b1; load_len = 8'd5;
    send(8'h01);
    load_req = 1'b0;
    chk("il_start", start, 1);
    tick();
    chk("il_err_sticky", err, 1);
    chk("il_done", load_done, 1);
    chk("il_busy", busy, 0);
    fetch(8'd0); chk("il_w0", ir, 16'h0001);
    chk("il_err_run", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("il_err_rst", err, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
